// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_pkg
// Description : Shared opcode constants and 16-bit instruction field positions
//               used by both the instruction encoder and the CPU decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

  // Opcodes that select a dedicated instruction format
  localparam logic [3:0] c_OP_WRITE = 4'h7;
  localparam logic [3:0] c_OP_LOAD  = 4'h8;
  localparam logic [3:0] c_OP_JMP   = 4'hC;

  // Field bit positions within the 16-bit instruction word
  localparam int c_OP_HI     = 15;
  localparam int c_OP_LO     = 12;
  localparam int c_RD_HI     = 11;  // rD, or imm[4:2] in WRITE format
  localparam int c_RD_LO     = 9;
  localparam int c_MODE_BIT  = 8;
  localparam int c_RA_HI     = 7;
  localparam int c_RA_LO     = 5;
  localparam int c_RB_HI     = 4;
  localparam int c_RB_LO     = 2;
  localparam int c_WIMM_HI   = 1;   // imm[1:0] in WRITE format
  localparam int c_WIMM_LO   = 0;
  localparam int c_IMM8_HI   = 7;   // LOAD/JMP 8-bit immediate
  localparam int c_IMM8_LO   = 0;
  localparam int c_IMM5_HI   = 4;   // generic-format 5-bit immediate
  localparam int c_IMM5_LO   = 0;

  typedef enum logic [1:0] {
    FMT_WRITE   = 2'd0,
    FMT_LONG    = 2'd1,
    FMT_GENERIC = 2'd2
  } instr_fmt_e;

  // Classify an opcode into the word layout it uses
  function automatic instr_fmt_e fmt_of(input logic [3:0] op);
    instr_fmt_e f;
    if (op == c_OP_WRITE)                         f = FMT_WRITE;
    else if ((op == c_OP_LOAD) || (op == c_OP_JMP)) f = FMT_LONG;
    else                                          f = FMT_GENERIC;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fifo
// Description : DEPTH x WIDTH circular-buffer FIFO with full/empty and a
//               registered head word that holds its value while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_push,
  input  logic [WIDTH-1:0] I_wdata,
  input  logic             I_pop,
  output logic [WIDTH-1:0] O_rdata,
  output logic             O_full,
  output logic             O_empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_FULL = DEPTH[c_PTR_W:0];
  localparam logic [c_PTR_W:0] c_ONE  = {{c_PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [WIDTH-1:0]   r_head;
  logic [c_PTR_W-1:0] w_rd_ptr_nxt;

  assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;
  assign O_full       = (r_count == c_FULL);
  assign O_empty      = (r_count == '0);
  assign O_rdata      = r_head;

  // Storage array; written at the tail on every push
  always_ff @(posedge I_clk) begin
    if (I_push) r_mem[r_wr_ptr] <= I_wdata;
  end

  // Pointers, occupancy and the head register presented to the reader
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (I_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (I_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      if (I_push && !I_pop)      r_count <= r_count + 1'b1;
      else if (I_pop && !I_push) r_count <= r_count - 1'b1;
      // Head follows the oldest entry; a push is ordered behind the current head
      if (O_empty && I_push)
        r_head <= I_wdata;
      else if (I_pop && (r_count != c_ONE))
        r_head <= r_mem[w_rd_ptr_nxt];
      else if (I_pop && I_push)
        r_head <= I_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Packs decoded instruction fields into 16-bit words, checks
//               immediate range, and streams words with sequential program
//               addresses through a small output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_enable,
  input  logic              I_valid,
  output logic              O_ready,
  input  logic [3:0]        I_opcode,
  input  logic [2:0]        I_rD,
  input  logic [2:0]        I_rA,
  input  logic [2:0]        I_rB,
  input  logic              I_mode,
  input  logic [7:0]        I_immediate,
  input  logic              I_imm_form,
  input  logic              I_addr_load,
  input  logic [ADDR_W-1:0] I_addr_value,
  output logic [15:0]       O_word,
  output logic [ADDR_W-1:0] O_addr,
  output logic              O_valid,
  input  logic              I_ready,
  output logic              O_err,
  input  logic              I_err_clr,
  output logic [15:0]       O_count
);

  instr_fmt_e        w_fmt;
  logic [15:0]       w_word;
  logic              w_range_chk;
  logic              w_range_bad;
  logic              w_accept;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;
  logic              r_err;

  assign w_fmt    = fmt_of(I_opcode);
  assign O_ready  = I_enable && !w_full;
  assign O_valid  = !w_empty;
  assign w_accept = I_valid && O_ready;
  assign w_pop    = O_valid && I_ready;
  assign O_addr   = r_addr;
  assign O_count  = r_count;
  assign O_err    = r_err;

  // imm5 must be a sign-extension of bit 4 wherever a 5-bit immediate is packed
  assign w_range_chk = (w_fmt == FMT_WRITE) || ((w_fmt == FMT_GENERIC) && I_imm_form);
  assign w_range_bad = w_range_chk && (I_immediate[7:5] != {3{I_immediate[4]}});

  // Field packing; out-of-range immediates are simply truncated
  always_comb begin
    w_word = '0;
    w_word[c_OP_HI:c_OP_LO] = I_opcode;
    w_word[c_MODE_BIT]      = I_mode;
    case (w_fmt)
      FMT_WRITE: begin
        w_word[c_RD_HI:c_RD_LO]     = I_immediate[4:2];
        w_word[c_RA_HI:c_RA_LO]     = I_rA;
        w_word[c_RB_HI:c_RB_LO]     = I_rB;
        w_word[c_WIMM_HI:c_WIMM_LO] = I_immediate[1:0];
      end
      FMT_LONG: begin
        w_word[c_RD_HI:c_RD_LO]     = I_rD;
        w_word[c_IMM8_HI:c_IMM8_LO] = I_immediate;
      end
      default: begin
        w_word[c_RD_HI:c_RD_LO] = I_rD;
        w_word[c_RA_HI:c_RA_LO] = I_rA;
        if (I_imm_form) w_word[c_IMM5_HI:c_IMM5_LO] = I_immediate[4:0];
        else            w_word[c_IMM5_HI:c_IMM5_LO] = {I_rB, 2'b00};
      end
    endcase
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .I_push  (w_accept),
    .I_wdata (w_word),
    .I_pop   (w_pop),
    .O_rdata (O_word),
    .O_full  (w_full),
    .O_empty (w_empty)
  );

  // Program address, emitted-word counter and sticky range-error flag
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      r_addr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop)
        r_addr <= r_addr + 1'b1;
      else if (I_addr_load && w_empty && !w_accept)
        r_addr <= I_addr_value;
      if (w_pop) r_count <= r_count + 1'b1;
      if (w_accept && w_range_bad) r_err <= 1'b1;
      else if (I_err_clr)          r_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder: directed vector table,
//               hand-written corner sequences and randomized traffic against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, vld, mode, form, aload, rdy, eclr;
  logic [3:0]  op;
  logic [2:0]  rd, ra, rb;
  logic [7:0]  imm;
  logic [15:0] aval;
  logic        o_ready, o_valid, o_err;
  logic [15:0] o_word, o_addr, o_count;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] m_last;
  logic [15:0] m_addr;
  logic [15:0] m_cnt;
  logic        m_err;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .I_clk(clk), .I_reset(rst), .I_enable(en), .I_valid(vld), .O_ready(o_ready),
    .I_opcode(op), .I_rD(rd), .I_rA(ra), .I_rB(rb), .I_mode(mode),
    .I_immediate(imm), .I_imm_form(form), .I_addr_load(aload),
    .I_addr_value(aval), .O_word(o_word), .O_addr(o_addr), .O_valid(o_valid),
    .I_ready(rdy), .O_err(o_err), .I_err_clr(eclr), .O_count(o_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Word value computed arithmetically from the format rules
  function automatic logic [15:0] m_enc(input int o, input int d, input int a, input int b,
                                        input int md, input int im, input int fm);
    int w;
    w = o * 4096 + md * 256;
    if (o == int'(c_OP_WRITE))
      w += ((im / 4) % 8) * 512 + a * 32 + b * 4 + (im % 4);
    else if (o == int'(c_OP_LOAD) || o == int'(c_OP_JMP))
      w += d * 512 + im;
    else
      w += d * 512 + a * 32 + (fm != 0 ? (im % 32) : b * 4);
    return w[15:0];
  endfunction

  // Immediate must fit in a signed 5-bit field where imm5 is used
  function automatic bit m_bad(input int o, input logic [7:0] im, input int fm);
    int s;
    bit uses5;
    s = int'($signed(im));
    uses5 = (o == int'(c_OP_WRITE)) ||
            (o != int'(c_OP_LOAD) && o != int'(c_OP_JMP) && fm != 0);
    return uses5 && (s < -16 || s > 15);
  endfunction

  task automatic check_state();
    check("valid", o_valid, mq.size() != 0);
    check("word",  o_word,  m_last);
    check("addr",  o_addr,  m_addr);
    check("count", o_count, m_cnt);
    check("err",   o_err,   m_err);
    check("ready", o_ready, en && (mq.size() < DEPTH));
  endtask

  // One clock with the currently driven inputs; model advances alongside
  task automatic cycle();
    bit acc, pop, was_empty;
    logic [15:0] w;
    was_empty = (mq.size() == 0);
    acc = vld && en && (mq.size() < DEPTH);
    pop = !was_empty && rdy;
    w = m_enc(op, rd, ra, rb, mode, imm, form);
    if (pop) begin
      void'(mq.pop_front());
      m_addr = m_addr + 16'd1;
      m_cnt  = m_cnt + 16'd1;
    end else if (aload && was_empty && !acc) begin
      m_addr = aval;
    end
    if (acc) mq.push_back(w);
    if (acc && m_bad(op, imm, form)) m_err = 1'b1;
    else if (eclr) m_err = 1'b0;
    if (mq.size() != 0) m_last = mq[0];
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic idle_inputs();
    vld = 0; aload = 0; eclr = 0; rdy = 0; en = 1;
  endtask

  task automatic set_fields(input logic [3:0] o, input logic [2:0] d, input logic [2:0] a,
                            input logic [2:0] b, input logic md, input logic [7:0] im,
                            input logic fm);
    op = o; rd = d; ra = a; rb = b; mode = md; imm = im; form = fm;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    mq.delete();
    m_last = 0; m_addr = 0; m_cnt = 0; m_err = 0;
    check("rst_valid", o_valid, 0);
    check("rst_word",  o_word,  0);
    check("rst_addr",  o_addr,  0);
    check("rst_count", o_count, 0);
    check("rst_err",   o_err,   0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_state();
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [2:0]  d, a, b;
    logic        md;
    logic [7:0]  im;
    logic        fm;
    logic [15:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] pushed[DEPTH];

  initial begin
    vecs[0] = '{c_OP_LOAD,  3'd3, 3'd0, 3'd0, 1'b1, 8'hA5, 1'b0, {c_OP_LOAD, 12'h7A5}, 1'b0};
    vecs[1] = '{c_OP_WRITE, 3'd0, 3'd2, 3'd5, 1'b0, 8'hFD, 1'b0,
                {c_OP_WRITE, 3'b111, 1'b0, 3'b010, 3'b101, 2'b01}, 1'b0};
    vecs[2] = '{c_OP_WRITE, 3'd0, 3'd2, 3'd5, 1'b0, 8'h1D, 1'b0,
                {c_OP_WRITE, 3'b111, 1'b0, 3'b010, 3'b101, 2'b01}, 1'b1};
    vecs[3] = '{4'h2, 3'd1, 3'd6, 3'd4, 1'b0, 8'h0B, 1'b0, {4'h2, 12'h2D0}, 1'b0};
    vecs[4] = '{4'h2, 3'd1, 3'd6, 3'd4, 1'b0, 8'h0B, 1'b1, {4'h2, 12'h2CB}, 1'b0};
    vecs[5] = '{c_OP_JMP, 3'd7, 3'd1, 3'd1, 1'b0, 8'h80, 1'b1, {c_OP_JMP, 12'hE80}, 1'b0};

    idle_inputs();
    set_fields(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0);
    aval = 16'h0000;
    do_reset();

    // LOAD: 1-cycle latency, then pop advances address and count
    set_fields(vecs[0].o, vecs[0].d, vecs[0].a, vecs[0].b, vecs[0].md, vecs[0].im, vecs[0].fm);
    vld = 1; rdy = 1;
    cycle();
    check("load_word", o_word, {c_OP_LOAD, 12'h7A5});
    check("load_addr", o_addr, 0);
    vld = 0;
    cycle();
    check("load_addr_after_pop",  o_addr,  1);
    check("load_count_after_pop", o_count, 1);

    // Directed vector table: push with memory stalled, inspect head and error, drain
    for (int i = 0; i < 6; i++) begin
      set_fields(vecs[i].o, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].md, vecs[i].im, vecs[i].fm);
      vld = 1; rdy = 0; eclr = 0;
      cycle();
      check($sformatf("vec%0d_word", i), o_word, vecs[i].exp_word);
      check($sformatf("vec%0d_err", i),  o_err,  vecs[i].exp_err);
      vld = 0;
      cycle();
      check($sformatf("vec%0d_err_hold", i), o_err, vecs[i].exp_err);
      rdy = 1; eclr = 1;
      cycle();
      check($sformatf("vec%0d_err_clr", i), o_err, 0);
      eclr = 0; rdy = 0;
    end

    // Set wins over a same-cycle clear
    set_fields(c_OP_WRITE, 3'd0, 3'd1, 3'd1, 1'b0, 8'h40, 1'b0);
    vld = 1; eclr = 1; rdy = 1;
    cycle();
    check("err_set_over_clr", o_err, 1);
    vld = 0;
    cycle();
    check("err_cleared", o_err, 0);
    idle_inputs();

    // Backpressure: DEPTH+1 attempts with memory stalled
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      set_fields(4'h3, 3'(i), 3'(i + 1), 3'(i + 2), 1'b1, 8'(i), 1'b0);
      if (i < DEPTH) pushed[i] = m_enc(4'h3, i, i + 1, i + 2, 1, i, 0);
      vld = 1;
      cycle();
    end
    check("bp_ready_low", o_ready, 0);
    vld = 0; rdy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("bp_word%0d", i), o_word, pushed[i]);
      check($sformatf("bp_addr%0d", i), o_addr, 16'(i));
      cycle();
    end
    check("bp_drained", o_valid, 0);
    check("bp_word_held", o_word, pushed[DEPTH-1]);

    // Address load while empty, wrap at the top of the address space
    idle_inputs();
    aload = 1; aval = 16'hFFFF;
    cycle();
    check("aload_value", o_addr, 16'hFFFF);
    aload = 0;
    set_fields(c_OP_LOAD, 3'd1, 3'd0, 3'd0, 1'b0, 8'h11, 1'b0);
    vld = 1;
    cycle();
    cycle();
    vld = 0;
    aload = 1; aval = 16'h1234;
    cycle();
    check("aload_ignored", o_addr, 16'hFFFF);
    aload = 0; rdy = 1;
    check("wrap_addr0", o_addr, 16'hFFFF);
    cycle();
    check("wrap_addr1", o_addr, 16'h0000);
    cycle();

    // Reset mid-stream with three words queued
    idle_inputs();
    set_fields(c_OP_JMP, 3'd2, 3'd0, 3'd0, 1'b1, 8'h33, 1'b0);
    vld = 1;
    cycle(); cycle(); cycle();
    vld = 0;
    check("mid_queued", o_valid, 1);
    #2;
    do_reset();
    rdy = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("post_rst_empty", o_valid, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      vld   = $urandom_range(0, 1);
      rdy   = ($urandom_range(0, 2) != 0);
      aload = ($urandom_range(0, 15) == 0);
      aval  = 16'($urandom);
      eclr  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: op = c_OP_WRITE;
        1: op = c_OP_LOAD;
        2: op = c_OP_JMP;
        default: op = 4'($urandom);
      endcase
      rd = 3'($urandom); ra = 3'($urandom); rb = 3'($urandom);
      mode = 1'($urandom); imm = 8'($urandom); form = 1'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
